bp_me_trace_arbiter: RTL

//  Shares one mock-LCE trace port among num_req_p trace node masters in ME tests.

---
 rtl/bp_me_trace_pkg.sv | 28 ++
 rtl/bp_me_trace_arbiter_if.sv | 37 +++
 rtl/bp_me_trace_id_fifo.sv | 74 +++++++
 rtl/bp_me_trace_arbiter.sv | 163 ++++++++++++++++
 4 files changed

// File: rtl/bp_me_trace_pkg.sv
// Shared types and constants for the ME trace-port arbiter.
// Packet width is derived from the dcache trace fields.
package bp_me_trace_pkg;

  typedef enum logic [1:0] {
    e_run,
    e_drain,
    e_done
  } bp_me_trace_arb_state_e;

  localparam int dcache_opcode_width_gp = 4;
  localparam int paddr_width_gp         = 40;
  localparam int dword_width_gp         = 64;

  function automatic int trace_pkt_width(
    input int op_w,
    input int paddr_w,
    input int data_w
  );
    return op_w + paddr_w + data_w;
  endfunction

  localparam int trace_pkt_width_gp =
    trace_pkt_width(dcache_opcode_width_gp,
                    paddr_width_gp,
                    dword_width_gp);

endpackage

// File: rtl/bp_me_trace_arbiter_if.sv
// Request/response and shared-LCE handshake bundle.
// slave = arbiter view, master = trace nodes + LCE side.
interface bp_me_trace_arbiter_if
  import bp_me_trace_pkg::*;
#(
  parameter int num_req_p    = 4,
  parameter int ring_width_p = trace_pkt_width_gp
);

  logic [num_req_p-1:0]              req_v_i;
  logic [num_req_p*ring_width_p-1:0] req_data_i;
  logic [num_req_p-1:0]              req_yumi_o;
  logic [num_req_p-1:0]              resp_v_o;
  logic [ring_width_p-1:0]           resp_data_o;
  logic [num_req_p-1:0]              resp_ready_i;
  logic                              lce_v_o;
  logic [ring_width_p-1:0]           lce_data_o;
  logic                              lce_ready_i;
  logic                              lce_v_i;
  logic [ring_width_p-1:0]           lce_data_i;
  logic                              lce_yumi_o;

  modport slave (
    input  req_v_i, req_data_i, resp_ready_i,
    input  lce_ready_i, lce_v_i, lce_data_i,
    output req_yumi_o, resp_v_o, resp_data_o,
    output lce_v_o, lce_data_o, lce_yumi_o
  );

  modport master (
    output req_v_i, req_data_i, resp_ready_i,
    output lce_ready_i, lce_v_i, lce_data_i,
    input  req_yumi_o, resp_v_o, resp_data_o,
    input  lce_v_o, lce_data_o, lce_yumi_o
  );

endinterface

// File: rtl/bp_me_trace_id_fifo.sv
// Circular-buffer FIFO of requester ids, in issue order.
// Head is presented combinationally for response routing.
module bp_me_trace_id_fifo
  import bp_me_trace_pkg::*;
#(
  parameter int els_p   = 16,
  parameter int width_p = 2
) (
  input  logic               clk_i,
  input  logic               reset_n_i,
  input  logic               push_i,
  input  logic               pop_i,
  input  logic [width_p-1:0] data_i,
  output logic [width_p-1:0] data_o,
  output logic               full_o,
  output logic               empty_o
);

  localparam int ptr_w_lp = (els_p > 1) ? $clog2(els_p) : 1;
  localparam int cnt_w_lp = $clog2(els_p + 1);

  logic [width_p-1:0]  mem_q [els_p];
  logic [width_p-1:0]  mem_d [els_p];
  logic [ptr_w_lp-1:0] wptr_q, wptr_d;
  logic [ptr_w_lp-1:0] rptr_q, rptr_d;
  logic [cnt_w_lp-1:0] cnt_q, cnt_d;
  logic                push_ok, pop_ok;

  function automatic logic [ptr_w_lp-1:0] nxt(
    input logic [ptr_w_lp-1:0] p
  );
    return (p == ptr_w_lp'(els_p - 1)) ? '0 : p + 1'b1;
  endfunction

  assign full_o  = (cnt_q == cnt_w_lp'(els_p));
  assign empty_o = (cnt_q == '0);
  assign data_o  = mem_q[rptr_q];
  assign push_ok = push_i & ~full_o;
  assign pop_ok  = pop_i & ~empty_o;

  always_comb begin
    mem_d  = mem_q;
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    cnt_d  = cnt_q;
    if (push_ok) begin
      mem_d[wptr_q] = data_i;
      wptr_d        = nxt(wptr_q);
    end
    if (pop_ok)
      rptr_d = nxt(rptr_q);
    unique case ({push_ok, pop_ok})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      for (int i = 0; i < els_p; i++)
        mem_q[i] <= '0;
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      mem_q  <= mem_d;
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      cnt_q  <= cnt_d;
    end
  end

endmodule

// File: rtl/bp_me_trace_arbiter.sv
// Round-robin share of one mock-LCE trace port among trace nodes,
// with per-node credits, in-order response routing and drain/done FSM.
module bp_me_trace_arbiter
  import bp_me_trace_pkg::*;
#(
  parameter int num_req_p         = 4,
  parameter int ring_width_p      = trace_pkt_width_gp,
  parameter int max_outstanding_p = 4,
  parameter int cnt_width_p       = 32
) (
  input  logic                   clk_i,
  input  logic                   reset_n_i,
  bp_me_trace_arbiter_if.slave   io,
  input  logic [num_req_p-1:0]   done_i,
  output logic                   all_done_o,
  output logic [cnt_width_p-1:0] clock_cnt_o,
  output logic [cnt_width_p-1:0] issue_cnt_o,
  output logic                   err_o
);

  localparam int id_w_lp   = (num_req_p > 1) ? $clog2(num_req_p) : 1;
  localparam int cred_w_lp = $clog2(max_outstanding_p + 1);
  localparam int fifo_els_lp = num_req_p * max_outstanding_p;
  localparam logic [cred_w_lp-1:0] max_cred_lp =
    cred_w_lp'(max_outstanding_p);

  bp_me_trace_arb_state_e state_q, state_d;

  logic [id_w_lp-1:0]     rr_q, rr_d;
  logic [cred_w_lp-1:0]   credit_q [num_req_p];
  logic [cred_w_lp-1:0]   credit_d [num_req_p];
  logic [cnt_width_p-1:0] clock_cnt_q, clock_cnt_d;
  logic [cnt_width_p-1:0] issue_cnt_q, issue_cnt_d;
  logic                   err_q, err_d;
  logic                   all_done_q, all_done_d;

  logic [num_req_p-1:0] eligible, grant;
  logic [id_w_lp-1:0]   gidx, head_id;
  logic                 found, issue, pop;
  logic                 fifo_full, fifo_empty;

  always_comb begin
    eligible = '0;
    grant    = '0;
    gidx     = '0;
    found    = 1'b0;
    for (int i = 0; i < num_req_p; i++)
      eligible[i] = reset_n_i & io.req_v_i[i]
                  & (credit_q[i] < max_cred_lp)
                  & ~fifo_full & (state_q == e_run);
    for (int k = 0; k < num_req_p; k++) begin
      if (!found && eligible[(int'(rr_q) + k) % num_req_p]) begin
        found = 1'b1;
        grant[(int'(rr_q) + k) % num_req_p] = 1'b1;
        gidx = id_w_lp'((int'(rr_q) + k) % num_req_p);
      end
    end
  end

  assign issue         = found & io.lce_ready_i;
  assign io.lce_v_o    = found;
  assign io.lce_data_o = found
    ? io.req_data_i[gidx*ring_width_p +: ring_width_p]
    : '0;
  assign io.req_yumi_o = grant & {num_req_p{io.lce_ready_i}};

  // An empty FIFO with a response pending is a stray packet: sink it.
  always_comb begin
    io.resp_v_o = '0;
    if (reset_n_i & io.lce_v_i & ~fifo_empty)
      io.resp_v_o[head_id] = 1'b1;
  end

  assign io.resp_data_o = io.lce_data_i;
  assign pop = reset_n_i & io.lce_v_i & ~fifo_empty
             & io.resp_ready_i[head_id];
  assign io.lce_yumi_o = reset_n_i & io.lce_v_i
                       & (fifo_empty | io.resp_ready_i[head_id]);

  bp_me_trace_id_fifo #(
    .els_p   (fifo_els_lp),
    .width_p (id_w_lp)
  ) u_id_fifo (
    .clk_i     (clk_i),
    .reset_n_i (reset_n_i),
    .push_i    (issue),
    .pop_i     (pop),
    .data_i    (gidx),
    .data_o    (head_id),
    .full_o    (fifo_full),
    .empty_o   (fifo_empty)
  );

  always_comb begin
    for (int i = 0; i < num_req_p; i++) begin
      credit_d[i] = credit_q[i];
      unique case ({issue & grant[i],
                    pop & (head_id == id_w_lp'(i))})
        2'b10:   credit_d[i] = credit_q[i] + 1'b1;
        2'b01:   credit_d[i] = credit_q[i] - 1'b1;
        default: credit_d[i] = credit_q[i];
      endcase
    end
  end

  always_comb begin
    rr_d = rr_q;
    if (issue)
      rr_d = (gidx == id_w_lp'(num_req_p - 1)) ? '0 : gidx + 1'b1;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      e_run:
        if (&done_i)
          state_d = (fifo_empty & ~issue) ? e_done : e_drain;
      e_drain:
        if (fifo_empty & ~io.lce_v_i)
          state_d = e_done;
      e_done:  state_d = e_done;
      default: state_d = e_run;
    endcase
  end

  always_comb begin
    all_done_d  = (state_d == e_done);
    err_d       = err_q | (io.lce_v_i & fifo_empty);
    clock_cnt_d = clock_cnt_q;
    issue_cnt_d = issue_cnt_q;
    if (state_q != e_done && clock_cnt_q != '1)
      clock_cnt_d = clock_cnt_q + 1'b1;
    if (issue && issue_cnt_q != '1)
      issue_cnt_d = issue_cnt_q + 1'b1;
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q     <= e_run;
      rr_q        <= '0;
      for (int i = 0; i < num_req_p; i++)
        credit_q[i] <= '0;
      clock_cnt_q <= '0;
      issue_cnt_q <= '0;
      err_q       <= 1'b0;
      all_done_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      rr_q        <= rr_d;
      credit_q    <= credit_d;
      clock_cnt_q <= clock_cnt_d;
      issue_cnt_q <= issue_cnt_d;
      err_q       <= err_d;
      all_done_q  <= all_done_d;
    end
  end

  assign all_done_o  = all_done_q;
  assign clock_cnt_o = clock_cnt_q;
  assign issue_cnt_o = issue_cnt_q;
  assign err_o       = err_q;

endmodule
